// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability-counter debounce,
// registered press/release pulses. Define BTN_DEBOUNCE_AUTOREPEAT_EN for held-button repeat.
module btn_debounce #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic             disagree;
  logic             expire;
  logic             rise;
  logic             fall;
  logic             press_next;

  // Debounce state is carried by btn_level/cnt: cnt==0 is a settled level,
  // cnt>0 means a disagreeing run is in progress toward a toggle.
  always_comb begin
    disagree = (sync1 != btn_level);
    expire   = disagree && (cnt == CNT_LAST);
    rise     = expire && sync1;
    fall     = expire && !sync1;
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt;
  logic             rpt_first;
  logic             rpt_tick;

  // rpt_first selects the long initial delay until the first repeat has fired.
  // A release landing on a tick wins: the tick is dropped.
  always_comb begin
    rpt_tick   = btn_level && !fall && (rpt == (rpt_first ? DELAY_LAST : PERIOD_LAST));
    press_next = rise || rpt_tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt       <= '0;
      rpt_first <= 1'b0;
    end else if (rise) begin
      rpt       <= '0;
      rpt_first <= 1'b1;
    end else if (fall) begin
      rpt       <= '0;
      rpt_first <= 1'b0;
    end else if (rpt_tick) begin
      rpt       <= '0;
      rpt_first <= 1'b0;
    end else if (btn_level) begin
      rpt <= rpt + RPT_W'(1);
    end
  end
`else
  always_comb begin
    press_next = rise;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0       <= 1'b0;
      sync1       <= 1'b0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync0       <= btn_in;
      sync1       <= sync0;
      btn_press   <= press_next;
      btn_release <= fall;
      if (!disagree) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level <= sync1;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Conditions one raw, asynchronous push-button input for the Pong game logic. Synchronizes the pin into the `clk` domain through a two-flop chain of plain reset-to-0 D flops. Filters contact bounce with a stability counter. Produces a clean level plus single-cycle press and release pulses that the paddle and serve/menu logic consume directly. An optional auto-repeat lets a held button emit periodic press pulses for continuous paddle motion.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1_000_000: consecutive synchronized samples that must disagree with `btn_level` before it toggles (10 ms at 100 MHz). Must be ≥1.
- `REPEAT_DELAY`, default 50_000_000: cycles from the initial press pulse to the first repeat pulse. Must be ≥1.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent repeat pulses. Must be ≥1.

Ports:
- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: reset `rst`, synchronous, active-high; clock `clk`.
- `btn_in` in 1: raw button pin, asynchronous, active-high.
- `btn_level` out 1: debounced button state.
- `btn_press` out 1: one-cycle pulse on each debounced rising edge, and on each auto-repeat tick.
- `btn_release` out 1: one-cycle pulse on each debounced falling edge.

## Operation
- Synchronizer:
  - `sync0 <= btn_in`, then `sync1 <= sync0`.
  - Both flops reset to 0. No other logic reads `sync0`.
- Stability counter `cnt`:
  - Width `$clog2(STABLE_CYCLES)`, minimum 1.
  - If `sync1 == btn_level`: `cnt <= 0`.
  - If `sync1 != btn_level` and `cnt != STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - If `sync1 != btn_level` and `cnt == STABLE_CYCLES-1`: `btn_level <= sync1`, `cnt <= 0`.
  - Any single agreeing sample restarts the count, so glitches shorter than `STABLE_CYCLES` samples are rejected.
- Edge pulses:
  - `btn_press` and `btn_release` are registered.
  - Each is asserted in exactly the cycle where `btn_level` first shows its new value.
  - They are never asserted together.
- Debounce states (encoded by `btn_level`/`cnt`):
  - LOW: level 0, cnt 0.
  - RISING: level 0, cnt > 0.
  - HIGH: level 1, cnt 0.
  - FALLING: level 1, cnt > 0.
  - RISING returns to LOW, and FALLING returns to HIGH, on any agreeing sample.
- Reset values:
  - `btn_level`, `btn_press`, `btn_release`, `sync0`, `sync1`, `cnt`, and the repeat counter are all 0.
  - A button held through reset is reported as a fresh press `STABLE_CYCLES+1` cycles after `rst` deasserts.
  - Reset asserted mid-count or mid-repeat aborts everything; no pulse is emitted on or after the reset edge.

## Timing
- Latency, with edge 0 being the first posedge that samples the new `btn_in`:
  - `sync1` updates after edge 1.
  - `btn_level` and the edge pulse become visible after edge `STABLE_CYCLES+1`.
  - Total input-to-output latency is `STABLE_CYCLES+2` cycles.
- Pulse width: exactly 1 cycle. The next possible edge pulse is at least `STABLE_CYCLES` cycles later.
- Repeat counter `rpt`:
  - Width `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))`.
  - Cleared in the press-pulse cycle.
  - Increments while `btn_level` is 1.
  - First repeat pulse comes exactly `REPEAT_DELAY` cycles after the initial press pulse; each later one comes `REPEAT_PERIOD` cycles after the previous.
  - `rpt` reloads 0 on each repeat.
- Release boundary:
  - A debounced release clears `rpt` and suppresses any repeat tick that would coincide with the release cycle.
  - In that cycle only `btn_release` pulses.

## Configuration
- Macro `BTN_DEBOUNCE_AUTOREPEAT_EN`.
- Defined: the repeat counter and repeat pulses on `btn_press` are implemented as described above.
- Undefined:
  - No repeat counter is synthesized, and `REPEAT_DELAY`/`REPEAT_PERIOD` are ignored.
  - `btn_press` pulses exactly once per debounced rising edge, however long the button is held.

## Test plan
Parameters for all scenarios: `STABLE_CYCLES=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=3`.
- Clean press: `btn_in` rises before edge 0 and is held → `btn_level` is 1 and `btn_press` is 1 for one cycle after edge 5. `btn_release` stays 0.
- Bounce reject:
  - Stimulus: `btn_in` high for 3 cycles, low for 1, high for 3, then low.
  - Required: `btn_level`, `btn_press` and `btn_release` stay 0 throughout.
- Clean release: from HIGH, drop `btn_in` and hold low → `btn_release` pulses once, 6 cycles after the first low sample. `btn_level` is 0 in that same cycle.
- Auto-repeat (macro defined): hold for 30 cycles after the press pulse at cycle P → `btn_press` pulses at P, P+10, P+13, P+16 … P+28.
  - Without the macro: only P.
- Release vs. repeat tick: arrange the debounced release for the exact cycle a repeat would fire → only `btn_release` asserts, and no later `btn_press`.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle while in RISING with `cnt=2`, button still held.
  - Required: all outputs are 0 after the reset edge, and the press pulse occurs 5 cycles after `rst` deasserts.
